// File: rtl/multiboot_arbiter.sv
// Reboot-request arbiter for the ICAP multiboot path: picks a source, confirms its hold, fires the reboot pulse.
// Optional watchdog reboot into slot 0 is enabled by defining MULTIBOOT_WDT_EN.
module multiboot_arbiter #(
    parameter int          NREQ           = 3,
    parameter int          NSLOT          = 3,
    parameter logic [23:0] SLOT0_ADDR     = 24'h000000,
    parameter logic [23:0] SLOT_STRIDE    = 24'h058000,
    parameter int          HOLD_CYCLES    = 16,
    parameter int          PULSE_CYCLES   = 8,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          WDT_CYCLES     = 1048576
) (
    input  logic              CLK,
    input  logic              MBT_RESET,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_slot,
`ifdef MULTIBOOT_WDT_EN
    input  logic              wdt_kick,
`endif
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [23:0]       spi_addr,
    output logic              mbt_reboot,
    output logic              err_slot,
    output logic              timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_PULSE, S_WAIT} state_t;

    localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] PULSE_LAST   = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t          r_state, w_state_next;
    logic [NREQ-1:0] r_grant, w_grant_next;
    logic            r_busy, w_busy_next;
    logic [23:0]     r_addr, w_addr_next;
    logic            r_reboot, w_reboot_next;
    logic            r_err, w_err_next;
    logic            r_timeout, w_timeout_next;
    logic [31:0]     r_cnt, w_cnt_next;

    logic [2:0]      w_slot [NREQ];
    logic [2:0]      w_sel_slot;
    logic [NREQ-1:0] w_onehot;
    logic [23:0]     w_map_addr;
    logic            w_wdt_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign w_slot[gi] = req_slot[3*gi +: 3];
        end
    endgenerate

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_sel_slot = '0;
        w_onehot   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_sel_slot  = w_slot[i];
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_map_addr = SLOT0_ADDR + 24'(w_sel_slot) * SLOT_STRIDE;

`ifdef MULTIBOOT_WDT_EN
    localparam logic [19:0] WDT_LAST = 20'(WDT_CYCLES - 1);

    logic [19:0] r_wdt;
    logic        r_wdt_pend;
    logic        w_pend_clr;

    assign w_wdt_req  = r_wdt_pend | (r_wdt == WDT_LAST);
    assign w_pend_clr = (r_state == S_IDLE) && w_wdt_req;

    always_ff @(posedge CLK or posedge MBT_RESET) begin
        if (MBT_RESET) begin
            r_wdt      <= '0;
            r_wdt_pend <= 1'b0;
        end else begin
            if (w_pend_clr)
                r_wdt_pend <= 1'b0;
            else if (r_wdt == WDT_LAST)
                r_wdt_pend <= 1'b1;
            if (wdt_kick || r_busy)
                r_wdt <= '0;
            else if (r_wdt != WDT_LAST)
                r_wdt <= r_wdt + 20'd1;
        end
    end
`else
    assign w_wdt_req = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_addr_next    = r_addr;
        w_reboot_next  = r_reboot;
        w_err_next     = 1'b0;
        w_timeout_next = r_timeout;
        w_cnt_next     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_wdt_req) begin
                    // Watchdog reboot skips confirmation and always targets the golden image.
                    w_state_next   = S_PULSE;
                    w_reboot_next  = 1'b1;
                    w_addr_next    = SLOT0_ADDR;
                    w_grant_next   = '0;
                    w_timeout_next = 1'b0;
                    w_cnt_next     = '0;
                end else if (|req) begin
                    if ({29'd0, w_sel_slot} >= 32'(NSLOT)) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_state_next   = S_ARM;
                        w_grant_next   = w_onehot;
                        w_addr_next    = w_map_addr;
                        w_timeout_next = 1'b0;
                        w_cnt_next     = '0;
                    end
                end
            end
            S_ARM: begin
                if (!(|(req & r_grant))) begin
                    w_state_next = S_IDLE;
                    w_grant_next = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_next  = S_PULSE;
                    w_reboot_next = 1'b1;
                    w_cnt_next    = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_next  = S_WAIT;
                    w_reboot_next = 1'b0;
                    w_cnt_next    = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_WAIT: begin
                if (r_cnt == TIMEOUT_LAST) begin
                    w_state_next   = S_IDLE;
                    w_timeout_next = 1'b1;
                    w_grant_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_grant_next  = '0;
                w_reboot_next = 1'b0;
            end
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge CLK or posedge MBT_RESET) begin
        if (MBT_RESET) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_addr    <= SLOT0_ADDR;
            r_reboot  <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_busy    <= w_busy_next;
            r_addr    <= w_addr_next;
            r_reboot  <= w_reboot_next;
            r_err     <= w_err_next;
            r_timeout <= w_timeout_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign spi_addr   = r_addr;
    assign mbt_reboot = r_reboot;
    assign err_slot   = r_err;
    assign timeout    = r_timeout;

endmodule
